// File: rtl/neuron_sweep_scheduler.sv
// Sweeps the shared IF-neuron datapath over every post-synaptic neuron for input
// events, time-step fire/reset and end-of-sample clear, queuing spikes for AER out.
module neuron_sweep_scheduler #(
  parameter int POST_NEUR_NUM   = 256,
  parameter int POST_ADDR_WIDTH = 8,
  parameter int AER_WIDTH       = 12,
  parameter int TIME_STEP       = 8,
  parameter int SPK_FIFO_DEPTH  = 4,
  localparam int TS_WIDTH = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
  input  logic                                 CLK,
  input  logic                                 RSTN,
  input  logic                                 aer_in_req,
  input  logic [AER_WIDTH-1:0]                 aer_in_addr,
  output logic                                 aer_in_ack,
  input  logic                                 step_end_req,
  output logic                                 step_end_ack,
  output logic                                 neur_ren,
  output logic [POST_ADDR_WIDTH-1:0]           neur_raddr,
  output logic                                 neur_wen,
  output logic [POST_ADDR_WIDTH-1:0]           neur_waddr,
  output logic [AER_WIDTH+POST_ADDR_WIDTH-1:0] syn_raddr,
  output logic                                 neuron_event,
  output logic                                 time_step_event,
  output logic                                 time_ref_event,
  output logic [TS_WIDTH-1:0]                  current_time_step,
  input  logic                                 spike_in,
  output logic                                 aer_out_valid,
  output logic [POST_ADDR_WIDTH-1:0]           aer_out_addr,
  input  logic                                 aer_out_ready,
  output logic                                 sample_done,
  output logic                                 busy
);

  localparam int IDX_WIDTH = POST_ADDR_WIDTH + 1;
  localparam int FIFO_AW   = $clog2(SPK_FIFO_DEPTH);
  localparam int CNT_WIDTH = FIFO_AW + 1;
  localparam logic [IDX_WIDTH-1:0] IDX_END     = IDX_WIDTH'(POST_NEUR_NUM);
  localparam logic [CNT_WIDTH-1:0] CNT_RESERVE = CNT_WIDTH'(SPK_FIFO_DEPTH - 2);
  localparam logic [TS_WIDTH-1:0]  TS_LAST     = TS_WIDTH'(TIME_STEP - 1);

  typedef enum logic [2:0] {IDLE, EVT, STEP, REF, DRAIN} state_t;

  state_t                     state, next_state;
  logic [IDX_WIDTH-1:0]       rd_idx;
  logic                       wr_valid;
  logic [POST_ADDR_WIDTH-1:0] wr_addr;
  logic [AER_WIDTH-1:0]       aer_latch;
  logic [TS_WIDTH-1:0]        ts_count;
  logic                       ack_prev;
  logic [POST_ADDR_WIDTH-1:0] fifo_mem [SPK_FIFO_DEPTH];
  logic [FIFO_AW-1:0]         wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]       fifo_count;
  logic rd_done, sweep_done, idx_clear, latch_aer, ts_inc, ts_clear, push, pop;

  assign rd_done    = (rd_idx == IDX_END);
  assign sweep_done = rd_done && !wr_valid;
  assign push       = (state == STEP) && wr_valid && spike_in;
  assign pop        = aer_out_valid && aer_out_ready;

  // A sweep ends once the last read's write cycle has passed; the FIFO slot
  // check in STEP keeps room for the neuron whose write is still in flight.
  always_comb begin
    next_state   = state;
    idx_clear    = 1'b0;
    latch_aer    = 1'b0;
    ts_inc       = 1'b0;
    ts_clear     = 1'b0;
    neur_ren     = 1'b0;
    aer_in_ack   = 1'b0;
    step_end_ack = 1'b0;
    sample_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!ack_prev) begin
          if (aer_in_req) begin
            latch_aer  = 1'b1;
            idx_clear  = 1'b1;
            next_state = EVT;
          end else if (step_end_req) begin
            idx_clear  = 1'b1;
            next_state = STEP;
          end
        end
      end
      EVT: begin
        neur_ren = !rd_done;
        if (sweep_done) begin
          aer_in_ack = 1'b1;
          next_state = IDLE;
        end
      end
      STEP: begin
        neur_ren = !rd_done && (fifo_count <= CNT_RESERVE);
        if (sweep_done) begin
          if (ts_count == TS_LAST) begin
            idx_clear  = 1'b1;
            next_state = REF;
          end else begin
            ts_inc     = 1'b1;
            next_state = DRAIN;
          end
        end
      end
      REF: begin
        neur_ren = !rd_done;
        if (sweep_done) begin
          sample_done = 1'b1;
          ts_clear    = 1'b1;
          next_state  = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_count == '0) begin
          step_end_ack = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign neur_raddr        = neur_ren ? rd_idx[POST_ADDR_WIDTH-1:0] : '0;
  assign syn_raddr         = (state == EVT && neur_ren) ? {aer_latch, neur_raddr} : '0;
  assign neur_wen          = wr_valid;
  assign neur_waddr        = wr_valid ? wr_addr : '0;
  assign neuron_event      = wr_valid && (state == EVT);
  assign time_step_event   = wr_valid && (state == STEP);
  assign time_ref_event    = wr_valid && (state == REF);
  assign current_time_step = ts_count;
  assign busy              = (state != IDLE);
  assign aer_out_valid     = (fifo_count != '0);
  assign aer_out_addr      = aer_out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      rd_idx    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      aer_latch <= '0;
      ts_count  <= '0;
      ack_prev  <= 1'b0;
    end else begin
      state    <= next_state;
      ack_prev <= aer_in_ack || step_end_ack;
      wr_valid <= neur_ren;
      if (neur_ren)
        wr_addr <= neur_raddr;
      if (idx_clear)
        rd_idx <= '0;
      else if (neur_ren)
        rd_idx <= rd_idx + IDX_WIDTH'(1);
      if (latch_aer)
        aer_latch <= aer_in_addr;
      if (ts_clear)
        ts_count <= '0;
      else if (ts_inc)
        ts_count <= ts_count + TS_WIDTH'(1);
    end
  end

  // Spike FIFO storage needs no reset; the head is masked while empty.
  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem[wr_ptr] <= wr_addr;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sweep_scheduler.sv
// Bench for neuron_sweep_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_neuron_sweep_scheduler;

  localparam int N     = 8;
  localparam int PAW   = 8;
  localparam int AW    = 12;
  localparam int TS    = 8;
  localparam int DEPTH = 4;
  localparam int TSW   = 3;

  logic              CLK;
  logic              RSTN;
  logic              aer_in_req;
  logic [AW-1:0]     aer_in_addr;
  logic              aer_in_ack;
  logic              step_end_req;
  logic              step_end_ack;
  logic              neur_ren;
  logic [PAW-1:0]    neur_raddr;
  logic              neur_wen;
  logic [PAW-1:0]    neur_waddr;
  logic [AW+PAW-1:0] syn_raddr;
  logic              neuron_event;
  logic              time_step_event;
  logic              time_ref_event;
  logic [TSW-1:0]    current_time_step;
  logic              spike_in;
  logic              aer_out_valid;
  logic [PAW-1:0]    aer_out_addr;
  logic              aer_out_ready;
  logic              sample_done;
  logic              busy;

  neuron_sweep_scheduler #(
    .POST_NEUR_NUM(N), .POST_ADDR_WIDTH(PAW), .AER_WIDTH(AW),
    .TIME_STEP(TS), .SPK_FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .aer_in_req(aer_in_req), .aer_in_addr(aer_in_addr), .aer_in_ack(aer_in_ack),
    .step_end_req(step_end_req), .step_end_ack(step_end_ack),
    .neur_ren(neur_ren), .neur_raddr(neur_raddr),
    .neur_wen(neur_wen), .neur_waddr(neur_waddr), .syn_raddr(syn_raddr),
    .neuron_event(neuron_event), .time_step_event(time_step_event),
    .time_ref_event(time_ref_event), .current_time_step(current_time_step),
    .spike_in(spike_in), .aer_out_valid(aer_out_valid), .aer_out_addr(aer_out_addr),
    .aer_out_ready(aer_out_ready), .sample_done(sample_done), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Neuron-core stand-in: either a per-neuron spike pattern or random bits.
  int         ready_mode;
  bit         use_pattern;
  logic [7:0] spike_pattern;
  logic       spike_rand;
  assign spike_in = use_pattern ? spike_pattern[neur_waddr[2:0]] : spike_rand;

  // Model: mode 0 idle, 1 event sweep, 2 step sweep, 3 ref sweep, 4 drain.
  int         m_mode, m_next, m_inflight, m_ts;
  logic [AW-1:0] m_addr;
  bit         m_just_acked;
  int         m_fifo[$];

  int aer_ack_count, step_ack_count, sample_done_count, ref_event_count;
  int popped[$];

  function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  always @(negedge CLK) begin
    if (!RSTN) begin
      m_mode = 0; m_next = 0; m_inflight = -1; m_ts = 0; m_addr = '0;
      m_just_acked = 0; m_fifo.delete();
      check("rst_busy", busy, 0);
      check("rst_ren", neur_ren, 0);
      check("rst_wen", neur_wen, 0);
      check("rst_events", {neuron_event, time_step_event, time_ref_event}, 0);
      check("rst_acks", {aer_in_ack, step_end_ack, sample_done}, 0);
      check("rst_valid", aer_out_valid, 0);
      check("rst_ts", current_time_step, 0);
      check("rst_syn", syn_raddr, 0);
    end else begin
      bit sweeping, e_ren, e_wen, done, e_valid, e_aer_ack, e_step_ack, e_sd, ignore;
      logic [AW+PAW-1:0] e_syn;
      sweeping = (m_mode >= 1 && m_mode <= 3);
      if (m_mode == 2) e_ren = (m_next < N) && (m_fifo.size() <= DEPTH - 2);
      else             e_ren = sweeping && (m_next < N);
      e_wen      = (m_inflight >= 0);
      done       = sweeping && (m_next == N) && !e_wen;
      e_valid    = (m_fifo.size() != 0);
      e_aer_ack  = (m_mode == 1) && done;
      e_sd       = (m_mode == 3) && done;
      e_step_ack = (m_mode == 4) && !e_valid;
      e_syn      = (m_mode == 1 && e_ren) ? {m_addr, 8'(m_next)} : '0;

      check("ren", neur_ren, e_ren);
      if (e_ren) check("raddr", neur_raddr, m_next);
      check("wen", neur_wen, e_wen);
      if (e_wen) check("waddr", neur_waddr, m_inflight);
      check("neuron_event", neuron_event, e_wen && m_mode == 1);
      check("time_step_event", time_step_event, e_wen && m_mode == 2);
      check("time_ref_event", time_ref_event, e_wen && m_mode == 3);
      check("syn_raddr", syn_raddr, e_syn);
      check("aer_in_ack", aer_in_ack, e_aer_ack);
      check("step_end_ack", step_end_ack, e_step_ack);
      check("sample_done", sample_done, e_sd);
      check("busy", busy, m_mode != 0);
      check("time_step", current_time_step, m_ts);
      check("out_valid", aer_out_valid, e_valid);
      if (e_valid) check("out_addr", aer_out_addr, m_fifo[0]);

      if (aer_in_ack) aer_ack_count++;
      if (step_end_ack) step_ack_count++;
      if (sample_done) sample_done_count++;
      if (time_ref_event) ref_event_count++;
      if (aer_out_valid && aer_out_ready) popped.push_back(int'(aer_out_addr));

      if (e_valid && aer_out_ready) void'(m_fifo.pop_front());
      if (m_mode == 2 && e_wen && spike_in) m_fifo.push_back(m_inflight);
      m_inflight = e_ren ? m_next : -1;
      if (e_ren) m_next++;
      ignore = m_just_acked;
      m_just_acked = e_aer_ack || e_step_ack;
      case (m_mode)
        0: if (!ignore) begin
             if (aer_in_req) begin m_addr = aer_in_addr; m_mode = 1; m_next = 0; end
             else if (step_end_req) begin m_mode = 2; m_next = 0; end
           end
        1: if (done) m_mode = 0;
        2: if (done) begin
             if (m_ts == TS - 1) begin m_mode = 3; m_next = 0; end
             else begin m_ts++; m_mode = 4; end
           end
        3: if (done) begin m_ts = 0; m_mode = 4; end
        default: if (!e_valid) m_mode = 0;
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        1:       aer_out_ready = 1'b1;
        2:       aer_out_ready = 1'b0;
        default: aer_out_ready = 1'($urandom_range(0, 1));
      endcase
      spike_rand = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_ack(input int which, output int cyc);
    bit ok;
    ok = 0;
    cyc = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLK);
      if ((which == 0 && aer_in_ack) || (which == 1 && step_end_ack)) begin
        ok = 1;
        cyc = k;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no ack for request %0d expected one within 4000 cycles", which);
      finish_run();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic apply_event(input logic [AW-1:0] a);
    int c;
    aer_in_addr = a;
    aer_in_req  = 1'b1;
    wait_ack(0, c);
    @(posedge CLK); #1;
    aer_in_req = 1'b0;
  endtask

  task automatic apply_step();
    int c;
    step_end_req = 1'b1;
    wait_ack(1, c);
    @(posedge CLK); #1;
    step_end_req = 1'b0;
  endtask

  task automatic apply_both(input logic [AW-1:0] a);
    int c;
    int steps_before;
    steps_before = step_ack_count;
    aer_in_addr  = a;
    aer_in_req   = 1'b1;
    step_end_req = 1'b1;
    wait_ack(0, c);
    check("both_evt_first", step_ack_count - steps_before, 0);
    @(posedge CLK); #1;
    aer_in_req = 1'b0;
    @(negedge CLK);
    check("both_gap_busy", busy, 0);
    wait_ack(1, c);
    @(posedge CLK); #1;
    step_end_req = 1'b0;
  endtask

  initial begin
    int c;
    int refs_before, sd_before, acks_before;
    RSTN = 1'b0;
    aer_in_req = 1'b0; aer_in_addr = '0; step_end_req = 1'b0;
    aer_out_ready = 1'b0; spike_rand = 1'b0;
    ready_mode = 1; use_pattern = 1'b0; spike_pattern = '0;
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK);
    check("init_busy", busy, 0);
    check("init_ts", current_time_step, 0);
    idle(1);

    // Event sweep on address 0x005: reads 1..N, ack at N+2.
    aer_in_addr = 12'h005;
    aer_in_req  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("evt_first_ren", neur_ren, 1);
    check("evt_first_syn", syn_raddr, 20'h00500);
    wait_ack(0, c);
    check("evt_ack_cycle", c + 2, 10);
    @(posedge CLK); #1;
    aer_in_req = 1'b0;
    check("evt_keeps_ts", current_time_step, 0);
    idle(2);

    // Step with neurons 1 and 3 spiking, sink always ready.
    use_pattern = 1'b1;
    spike_pattern = 8'b0000_1010;
    popped.delete();
    apply_step();
    check("spk13_count", popped.size(), 2);
    check("spk13_first", (popped.size() > 0) ? popped[0] : -1, 1);
    check("spk13_second", (popped.size() > 1) ? popped[1] : -1, 3);
    check("spk13_ts", current_time_step, 1);
    idle(2);

    apply_both(12'h3a7);
    check("both_ts", current_time_step, 2);
    idle(2);

    // All neurons spike while the sink stalls: sweep must stall, then resume.
    spike_pattern = 8'hFF;
    ready_mode = 2;
    popped.delete();
    step_end_req = 1'b1;
    repeat (20) @(negedge CLK);
    check("bp_valid", aer_out_valid, 1);
    check("bp_stalled", neur_ren, 0);
    check("bp_busy", busy, 1);
    check("bp_head", aer_out_addr, 0);
    ready_mode = 1;
    wait_ack(1, c);
    @(posedge CLK); #1;
    step_end_req = 1'b0;
    check("bp_count", popped.size(), N);
    for (int i = 0; i < N; i++)
      check("bp_order", (i < popped.size()) ? popped[i] : -1, i);
    check("bp_ts", current_time_step, 3);
    idle(2);

    use_pattern = 1'b0;
    ready_mode = 0;
    repeat (4) begin
      apply_step();
      idle(2);
    end
    check("pre_ref_ts", current_time_step, 7);
    refs_before = ref_event_count;
    sd_before   = sample_done_count;
    apply_step();
    check("ref_events", ref_event_count - refs_before, N);
    check("ref_sample_done", sample_done_count - sd_before, 1);
    check("ref_ts", current_time_step, 0);
    idle(2);

    for (int t = 0; t < 40; t++) begin
      ready_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      case ($urandom_range(0, 2))
        0:       apply_event(12'($urandom()));
        1:       apply_step();
        default: apply_both(12'($urandom()));
      endcase
      idle($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of an event sweep.
    acks_before = aer_ack_count;
    aer_in_addr = 12'h0c3;
    aer_in_req  = 1'b1;
    repeat (4) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ren", neur_ren, 0);
    check("arst_wen", neur_wen, 0);
    check("arst_event", neuron_event, 0);
    check("arst_syn", syn_raddr, 0);
    @(posedge CLK); #1;
    aer_in_req = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    repeat (6) @(negedge CLK);
    check("arst_no_ack", aer_ack_count - acks_before, 0);
    check("arst_idle", busy, 0);
    finish_run();
  end

endmodule
